// File: rtl/uart_pkg.sv
// Shared UART datapath types: frame phases, latched frame configuration and
// data-length legality helpers.
package uart_pkg;

  localparam int MIN_DATA_BITS      = 5;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } frame_phase_e;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       stop2;
  } frame_cfg_t;

  function automatic logic data_bits_illegal(input logic [3:0] bits, input logic [3:0] max_bits);
    return (bits < 4'(MIN_DATA_BITS)) || (bits > max_bits);
  endfunction

  // Out-of-range lengths snap to the nearest legal length.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits, input logic [3:0] max_bits);
    if (bits < 4'(MIN_DATA_BITS)) begin
      return 4'(MIN_DATA_BITS);
    end
    if (bits > max_bits) begin
      return max_bits;
    end
    return bits;
  endfunction

endpackage

// File: rtl/uart_frame_sequencer_if.sv
// Control/status bundle between a frame sequencer and its controller; the
// controller side drives frame requests and configuration.
interface uart_frame_sequencer_if #(
  parameter int OVERSAMPLE  = uart_pkg::DEFAULT_OVERSAMPLE,
  parameter int FRAME_CNT_W = 4
);

  logic                          enable;
  logic                          frame_start;
  logic                          abort;
  logic [3:0]                    cfg_data_bits;
  logic                          cfg_parity_en;
  logic                          cfg_stop2;

  logic                          busy;
  logic [2:0]                    phase;
  logic [3:0]                    bit_index;
  logic [$clog2(OVERSAMPLE)-1:0] tick_count;
  logic                          sample_strobe;
  logic                          shift_strobe;
  logic                          frame_done;
  logic [FRAME_CNT_W-1:0]        frame_count;
  logic                          limit_wrap;
  logic                          cfg_error;

  modport master (
    output enable, frame_start, abort, cfg_data_bits, cfg_parity_en, cfg_stop2,
    input  busy, phase, bit_index, tick_count, sample_strobe, shift_strobe,
           frame_done, frame_count, limit_wrap, cfg_error
  );

  modport slave (
    input  enable, frame_start, abort, cfg_data_bits, cfg_parity_en, cfg_stop2,
    output busy, phase, bit_index, tick_count, sample_strobe, shift_strobe,
           frame_done, frame_count, limit_wrap, cfg_error
  );

endinterface

// File: rtl/uart_tick_counter.sv
// Oversample tick counter within one UART bit, with mid-bit sample and
// end-of-bit shift strobe decode.
module uart_tick_counter #(
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = OVERSAMPLE / 2
) (
  input  logic                          baud_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          active,
  input  logic                          clear,
  output logic [$clog2(OVERSAMPLE)-1:0] tick_count,
  output logic                          sample_strobe,
  output logic                          shift_strobe
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(SAMPLE_POINT);
  localparam logic [TICK_W-1:0] LAST_TICK   = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] tick_reg;
  logic              counting;

  assign counting = enable && active;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
    end else if (clear) begin
      tick_reg <= '0;
    end else if (counting) begin
      tick_reg <= (tick_reg == LAST_TICK) ? '0 : tick_reg + 1'b1;
    end
  end

  // Strobes decode the held count, so a disabled cycle can never fire one.
  assign tick_count    = tick_reg;
  assign sample_strobe = counting && (tick_reg == SAMPLE_TICK);
  assign shift_strobe  = counting && (tick_reg == LAST_TICK);

endmodule

// File: rtl/uart_frame_sequencer.sv
// Frame/bit sequencer for the UART TX shifter and RX sampler: phase FSM,
// per-frame latched configuration and a wrapping completed-frame counter.
module uart_frame_sequencer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = DEFAULT_OVERSAMPLE,
  parameter int SAMPLE_POINT  = OVERSAMPLE / 2,
  parameter int MAX_DATA_BITS = 9,
  parameter int FRAME_CNT_W   = 4,
  parameter int FRAME_LIMIT   = 10
) (
  input  logic                  baud_clk,
  input  logic                  rst_n,
  uart_frame_sequencer_if.slave seq
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [3:0]             MAX_BITS   = 4'(MAX_DATA_BITS);
  localparam logic [FRAME_CNT_W-1:0] LAST_COUNT = FRAME_CNT_W'(FRAME_LIMIT - 1);

  frame_phase_e           phase_reg;
  logic [3:0]             bit_index_reg;
  logic [FRAME_CNT_W-1:0] frame_count_reg;
  frame_cfg_t             cfg_reg;
  frame_cfg_t             cfg_next;

  logic              active;
  logic [TICK_W-1:0] tick_count;
  logic              sample_strobe;
  logic              shift_strobe;
  logic              last_data_bit;
  logic              last_stop_bit;
  logic              frame_end;
  logic              accept;

  uart_tick_counter #(
    .OVERSAMPLE   (OVERSAMPLE),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_tick (
    .baud_clk      (baud_clk),
    .rst_n         (rst_n),
    .enable        (seq.enable),
    .active        (active),
    .clear         (seq.abort),
    .tick_count    (tick_count),
    .sample_strobe (sample_strobe),
    .shift_strobe  (shift_strobe)
  );

  assign active        = (phase_reg != IDLE);
  assign last_data_bit = (bit_index_reg == cfg_reg.data_bits - 4'd1);
  assign last_stop_bit = (bit_index_reg == {3'b000, cfg_reg.stop2});
  assign frame_end     = shift_strobe && (phase_reg == STOP) && last_stop_bit;

  // A new frame is taken from IDLE or on the very last stop tick (back-to-back).
  assign accept = seq.enable && !seq.abort && seq.frame_start &&
                  ((phase_reg == IDLE) || frame_end);

  assign cfg_next.data_bits = clamp_data_bits(seq.cfg_data_bits, MAX_BITS);
  assign cfg_next.parity_en = seq.cfg_parity_en;
  assign cfg_next.stop2     = seq.cfg_stop2;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg       <= IDLE;
      bit_index_reg   <= '0;
      frame_count_reg <= '0;
      cfg_reg         <= '0;
    end else begin
      // A frame finishing under abort still counts; abort only blocks the restart.
      if (frame_end) begin
        frame_count_reg <= (frame_count_reg == LAST_COUNT) ? '0 : frame_count_reg + 1'b1;
      end
      if (seq.abort) begin
        phase_reg     <= IDLE;
        bit_index_reg <= '0;
      end else if (accept) begin
        phase_reg     <= START;
        bit_index_reg <= '0;
        cfg_reg       <= cfg_next;
      end else if (shift_strobe) begin
        case (phase_reg)
          START: begin
            phase_reg     <= DATA;
            bit_index_reg <= '0;
          end
          DATA: begin
            if (last_data_bit) begin
              phase_reg     <= cfg_reg.parity_en ? PARITY : STOP;
              bit_index_reg <= '0;
            end else begin
              bit_index_reg <= bit_index_reg + 1'b1;
            end
          end
          PARITY: begin
            phase_reg     <= STOP;
            bit_index_reg <= '0;
          end
          STOP: begin
            if (last_stop_bit) begin
              phase_reg     <= IDLE;
              bit_index_reg <= '0;
            end else begin
              bit_index_reg <= bit_index_reg + 1'b1;
            end
          end
          default: begin
            phase_reg     <= IDLE;
            bit_index_reg <= '0;
          end
        endcase
      end
    end
  end

  assign seq.busy          = active;
  assign seq.phase         = phase_reg;
  assign seq.bit_index     = bit_index_reg;
  assign seq.tick_count    = tick_count;
  assign seq.sample_strobe = sample_strobe;
  assign seq.shift_strobe  = shift_strobe;
  assign seq.frame_done    = frame_end;
  assign seq.frame_count   = frame_count_reg;
  assign seq.limit_wrap    = frame_end && (frame_count_reg == LAST_COUNT);
  assign seq.cfg_error     = accept && data_bits_illegal(seq.cfg_data_bits, MAX_BITS);

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Randomised and directed checks of uart_frame_sequencer against a
// position-in-frame reference model.
module tb_uart_frame_sequencer;

  localparam int OS          = 16;
  localparam int FRAME_CNT_W = 4;
  localparam int FRAME_LIMIT = 10;
  localparam int MAXD        = 9;

  logic baud_clk = 1'b0;
  logic rst_n    = 1'b0;

  always #5 baud_clk = ~baud_clk;

  uart_frame_sequencer_if #(.OVERSAMPLE(OS), .FRAME_CNT_W(FRAME_CNT_W)) sif ();

  uart_frame_sequencer #(
    .OVERSAMPLE    (OS),
    .SAMPLE_POINT  (OS / 2),
    .MAX_DATA_BITS (MAXD),
    .FRAME_CNT_W   (FRAME_CNT_W),
    .FRAME_LIMIT   (FRAME_LIMIT)
  ) dut (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .seq      (sif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is a list of bits; position counts enabled ticks.
  int m_active, m_pos, m_d, m_p, m_s, m_count, m_frames;

  int st_busy, st_samp_data, st_done, st_done_at, st_wrap, st_err, st_dis_strobe;
  int st_shift_ph[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phase_of(int b);
    if (b == 0) return 1;
    if (b <= m_d) return 2;
    if (m_p != 0 && b == m_d + 1) return 3;
    return 4;
  endfunction

  function automatic int index_of(int b);
    case (phase_of(b))
      2:       return b - 1;
      4:       return b - 1 - m_d - m_p;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_d = 0; m_p = 0; m_s = 1; m_count = 0;
  endtask

  task automatic clear_stats();
    st_busy = 0; st_samp_data = 0; st_done = 0; st_done_at = 0;
    st_wrap = 0; st_err = 0; st_dis_strobe = 0;
    for (int i = 0; i < 8; i++) st_shift_ph[i] = 0;
  endtask

  task automatic set_cfg(input int d, input int p, input int s2);
    sif.cfg_data_bits = 4'(d);
    sif.cfg_parity_en = (p != 0);
    sif.cfg_stop2     = (s2 != 0);
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int  b, t, ph, bi, d_in;
    bit  en, fs, ab, s2, pe, samp, shft, fin, acc, ill;
    @(negedge baud_clk);
    en = sif.enable; fs = sif.frame_start; ab = sif.abort;
    d_in = int'(sif.cfg_data_bits); pe = sif.cfg_parity_en; s2 = sif.cfg_stop2;
    b  = m_pos / OS;
    t  = m_pos % OS;
    ph = (m_active != 0) ? phase_of(b) : 0;
    bi = (m_active != 0) ? index_of(b) : 0;
    samp = (m_active != 0) && en && (t == OS / 2);
    shft = (m_active != 0) && en && (t == OS - 1);
    fin  = shft && (b == m_d + m_p + m_s);
    acc  = en && !ab && fs && ((m_active == 0) || fin);
    ill  = (d_in < 5) || (d_in > MAXD);

    check_eq("busy",          sif.busy, m_active);
    check_eq("phase",         sif.phase, ph);
    check_eq("bit_index",     sif.bit_index, bi);
    check_eq("tick_count",    sif.tick_count, (m_active != 0) ? t : 0);
    check_eq("sample_strobe", sif.sample_strobe, samp);
    check_eq("shift_strobe",  sif.shift_strobe, shft);
    check_eq("frame_done",    sif.frame_done, fin);
    check_eq("limit_wrap",    sif.limit_wrap, fin && (m_count == FRAME_LIMIT - 1));
    check_eq("cfg_error",     sif.cfg_error, acc && ill);
    check_eq("frame_count",   sif.frame_count, m_count);

    st_busy += int'(sif.busy);
    if (sif.sample_strobe && sif.phase == 3'd2) st_samp_data++;
    if (sif.frame_done) begin st_done++; st_done_at = st_busy; end
    if (sif.limit_wrap) st_wrap++;
    if (sif.cfg_error) st_err++;
    if (!en && (sif.sample_strobe || sif.shift_strobe)) st_dis_strobe++;
    if (sif.shift_strobe) st_shift_ph[sif.phase]++;

    @(posedge baud_clk);
    if (fin) begin
      m_count = (m_count + 1) % FRAME_LIMIT;
      m_frames++;
      $display("frame %0d complete: data_bits=%0d parity=%0d stop_bits=%0d frame_count=%0d",
               m_frames, m_d, m_p, m_s, m_count);
    end
    if (ab) begin
      if (m_active != 0 && !fin) $display("frame aborted at bit %0d tick %0d", b, t);
      m_active = 0; m_pos = 0;
    end else if (acc) begin
      m_active = 1; m_pos = 0;
      m_d = (d_in < 5) ? 5 : ((d_in > MAXD) ? MAXD : d_in);
      m_p = pe ? 1 : 0;
      m_s = s2 ? 2 : 1;
    end else if (fin) begin
      m_active = 0; m_pos = 0;
    end else if (m_active != 0 && en) begin
      m_pos++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sif.enable = 1'b0; sif.frame_start = 1'b0; sif.abort = 1'b0;
    set_cfg(8, 0, 0);
    repeat (3) @(posedge baud_clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sif.enable = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!sif.busy) break;
      step();
    end
    check_eq("idle_within_budget", sif.busy, 0);
  endtask

  task automatic start_frame();
    sif.frame_start = 1'b1;
    step();
    sif.frame_start = 1'b0;
  endtask

  task automatic wait_phase(input string tag, input int ph, input int idx, input int tick);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sif.phase == 3'(ph) && (idx < 0 || sif.bit_index == 4'(idx)) &&
          (tick < 0 || sif.tick_count == 4'(tick))) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq(tag, found, 1);
  endtask

  initial begin
    m_frames = 0;
    model_reset();
    clear_stats();
    do_reset();

    check_eq("reset_busy",        sif.busy, 0);
    check_eq("reset_phase",       sif.phase, 0);
    check_eq("reset_tick",        sif.tick_count, 0);
    check_eq("reset_frame_count", sif.frame_count, 0);

    // 8N1 single pulse
    set_cfg(8, 0, 0); clear_stats();
    start_frame();
    run_until_idle(400);
    check_eq("8n1_busy_cycles",  st_busy, 160);
    check_eq("8n1_data_samples", st_samp_data, 8);
    check_eq("8n1_done_at",      st_done_at, 160);
    check_eq("8n1_frame_count",  sif.frame_count, 1);

    // 7 data bits, parity, 2 stop bits
    set_cfg(7, 1, 1); clear_stats();
    start_frame();
    run_until_idle(400);
    check_eq("7p2_busy_cycles", st_busy, 176);
    check_eq("7p2_done_at",     st_done_at, 176);
    check_eq("7p2_start_bits",  st_shift_ph[1], 1);
    check_eq("7p2_data_bits",   st_shift_ph[2], 7);
    check_eq("7p2_parity_bits", st_shift_ph[3], 1);
    check_eq("7p2_stop_bits",   st_shift_ph[4], 2);

    // ten back-to-back 8N1 frames from a fresh count
    do_reset();
    set_cfg(8, 0, 0); clear_stats();
    sif.frame_start = 1'b1;
    for (int i = 0; i < 2000 && st_done < 9; i++) step();
    sif.frame_start = 1'b0;
    run_until_idle(400);
    check_eq("b2b_frames",      st_done, 10);
    check_eq("b2b_busy_cycles", st_busy, 1600);
    check_eq("b2b_wraps",       st_wrap, 1);
    check_eq("b2b_frame_count", sif.frame_count, 0);

    // abort at tick 5 of data bit 3, then immediate restart
    clear_stats();
    start_frame();
    wait_phase("abort_point_found", 2, 3, 5);
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    check_eq("abort_idle",        sif.busy, 0);
    check_eq("abort_no_done",     st_done, 0);
    check_eq("abort_count_kept",  sif.frame_count, 0);
    start_frame();
    check_eq("abort_restart_busy", sif.busy, 1);
    run_until_idle(400);
    check_eq("abort_restart_count", sif.frame_count, 1);

    // enable low for 20 cycles mid-DATA
    clear_stats();
    start_frame();
    wait_phase("data_reached", 2, -1, -1);
    repeat (5) step();
    sif.enable = 1'b0;
    repeat (20) step();
    sif.enable = 1'b1;
    run_until_idle(400);
    check_eq("hold_busy_cycles", st_busy, 180);
    check_eq("hold_done_at",     st_done_at, 180);
    check_eq("hold_no_strobes",  st_dis_strobe, 0);

    // illegal data length clamps to 9 bits
    set_cfg(12, 0, 0); clear_stats();
    start_frame();
    run_until_idle(400);
    check_eq("clamp_cfg_error",   st_err, 1);
    check_eq("clamp_busy_cycles", st_busy, 176);

    // asynchronous reset in the middle of STOP
    start_frame();
    wait_phase("stop_reached", 4, -1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy",        sif.busy, 0);
    check_eq("arst_phase",       sif.phase, 0);
    check_eq("arst_bit_index",   sif.bit_index, 0);
    check_eq("arst_tick",        sif.tick_count, 0);
    check_eq("arst_frame_count", sif.frame_count, 0);
    check_eq("arst_strobes",     {sif.sample_strobe, sif.shift_strobe, sif.frame_done}, 0);
    @(posedge baud_clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // randomised traffic; cfg churns mid-frame to exercise latching
    clear_stats();
    for (int i = 0; i < 2500; i++) begin
      sif.enable      = ($urandom_range(0, 9) != 0);
      sif.frame_start = ($urandom_range(0, 4) == 0);
      sif.abort       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) begin
        set_cfg($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      step();
    end
    sif.frame_start = 1'b0; sif.abort = 1'b0; sif.enable = 1'b1;
    run_until_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_frame_sequencer.md
Name: uart_frame_sequencer

Overview:
- Parametrised frame/bit sequencer for the UART datapath, running on the oversampled baud_clk.
- Tracks the tick within each bit and the bit within each frame (start, data, parity, stop).
- Issues mid-bit sample strobes and end-of-bit shift strobes, and counts completed frames against a programmable wrap limit.
- Drives both the TX shifter and the RX sampler.
- Replaces fixed 8N1/one-counter sequencing with runtime data length, parity, stop-bit count, back-to-back frames and abort.

Parameters:
- OVERSAMPLE, 16, baud_clk ticks per UART bit; must be >= 4 and a power of 2.
- SAMPLE_POINT, OVERSAMPLE/2, tick index at which sample_strobe fires.
- MAX_DATA_BITS, 9, largest supported data length.
- FRAME_CNT_W, 4, width of frame_count.
- FRAME_LIMIT, 10, frame_count wraps to 0 after reaching FRAME_LIMIT-1; must be <= 2**FRAME_CNT_W.

Ports:
- baud_clk  in  1  oversampled bit clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, all state and counters hold; no strobes are issued.
- frame_start  in  1  request to begin a frame; single-cycle or level.
- abort  in  1  terminate the current frame immediately.
- cfg_data_bits  in  4  data length, legal range 5..MAX_DATA_BITS.
- cfg_parity_en  in  1  insert a parity bit.
- cfg_stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- busy  out  1  high in any state other than IDLE.
- phase  out  3  current phase, encoded per frame_phase_e.
- bit_index  out  4  index within the current phase (data bit n, stop bit 0/1); 0 otherwise.
- tick_count  out  $clog2(OVERSAMPLE)  tick within the current bit.
- sample_strobe  out  1  asserted when tick_count == SAMPLE_POINT while busy.
- shift_strobe  out  1  asserted when tick_count == OVERSAMPLE-1 while busy.
- frame_done  out  1  one-cycle pulse on the final tick of the last stop bit.
- frame_count  out  FRAME_CNT_W  number of completed frames, modulo FRAME_LIMIT.
- limit_wrap  out  1  one-cycle pulse when frame_count wraps to 0.
- cfg_error  out  1  one-cycle pulse when a frame is accepted with an illegal cfg_data_bits.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - tick_count, bit_index, frame_count and the latched config clear to 0.
  - All strobes/pulses deassert; busy=0; phase=IDLE.
- States and encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Frame acceptance:
  - In IDLE with enable=1, frame_start=1 and abort=0, the next cycle enters START with tick_count=0 and bit_index=0.
  - cfg_* are latched at acceptance and held for the whole frame.
  - Input changes mid-frame have no effect.
- Illegal data length: cfg_data_bits <5 or >MAX_DATA_BITS is clamped to the nearest legal value and cfg_error pulses in the acceptance cycle.
- tick_count increments each enabled cycle and wraps OVERSAMPLE-1 -> 0. The bit or phase advances on that wrap (the shift_strobe cycle).
- Transitions on shift_strobe:
  - START -> DATA with bit_index=0.
  - DATA at bit_index == data_bits-1 -> PARITY if parity is enabled, else STOP; otherwise bit_index+1.
  - PARITY -> STOP with bit_index=0.
  - STOP at the last stop bit -> IDLE, or START if frame_start is high in that cycle (back-to-back, no idle tick). Otherwise bit_index+1.
- Frame length: exactly (1 + data_bits + parity + stop_bits) * OVERSAMPLE cycles from START entry to the end of the frame_done cycle. Example: 8N1 at 16x = 160 cycles.
- frame_done, frame_count and limit_wrap:
  - frame_done is coincident with the final shift_strobe.
  - frame_count increments in the same cycle (registered value is visible the next cycle).
  - At FRAME_LIMIT-1, frame_count goes to 0 and limit_wrap pulses.
- frame_start while busy, other than on the final stop tick, is ignored; there is no queueing.
- abort has priority over everything except reset:
  - Next cycle: IDLE, counters cleared, no frame_done, frame_count unchanged.
  - abort with frame_start on the final stop tick: the frame completes (frame_done, count++), no new frame starts, and the block returns to IDLE.
- enable=0: full hold, including tick_count. Strobes are combinational on the held state and gated by enable, so they stay low while disabled. abort is still honoured while enable=0.

Decomposition:
- Shared package uart_pkg:
  - frame_phase_e enum (IDLE/START/DATA/PARITY/STOP).
  - Constants MIN_DATA_BITS=5 and DEFAULT_OVERSAMPLE=16.
  - A frame_cfg_t struct {data_bits, parity_en, stop2}.
- One natural sub-module, uart_tick_counter: the OVERSAMPLE tick counter with enable/clear and the sample/shift strobe decode.
- The phase FSM and frame counter stay in the top module.

Test Plan:
- 8N1, OVERSAMPLE=16, single frame_start pulse -> busy for 160 cycles; 8 DATA sample_strobes at ticks 8; frame_done at cycle 160; frame_count 0 -> 1.
- 7 data bits, parity, 2 stop bits -> phase sequence START, DATA x7, PARITY, STOP x2; frame_done after 176 cycles.
- frame_start held high for 10 frames (8N1) -> no idle gaps; frame_count 0..9; 10th frame_done gives frame_count=0 with limit_wrap pulse.
- abort at tick 5 of DATA bit 3 -> IDLE next cycle; no frame_done; frame_count unchanged; a new frame_start is accepted the following cycle.
- enable low for 20 cycles mid-DATA -> tick_count/bit_index frozen, no strobes; frame completes exactly 20 cycles late.
- cfg_data_bits=12 at start -> cfg_error pulse; frame runs with 9 data bits (9N1 = 176 cycles); rst_n asserted mid-STOP -> all outputs 0 immediately.
